// File: rtl/sigdata_gen.sv
// sigdata_gen: request-driven word source for a downstream consumer.
//
// Each rising edge of ask_for_data produces exactly one new word LATENCY cycles later.
// Requests that arrive during a countdown are queued in a saturating pending counter.
// Requests that arrive while that counter is saturated are dropped and set a sticky overflow
// flag. An optional word budget stops the source permanently until reset.
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   LATENCY    cycles from the detected request edge to the data_vld cycle (>= 1)
//   INIT       reset value of data
//   TAPS       Galois LFSR feedback mask
//   PEND_W     width of the pending-request counter
//   NUM_WORDS  words to emit before done; 0 = unlimited
//
// Ports:
//   sclk          clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   ask_for_data  request input; each rising edge asks for one word
//   mode          00 increment, 01 decrement, 10 LFSR, 11 hold
//   data          current word
//   data_vld      high in the cycle whose closing edge loads the next word into data
//   busy          countdown in progress
//   done          word budget exhausted (sticky until rst)
//   ovf           sticky: a request was lost to pending-counter saturation
//   parity        (only with SIGDATA_PARITY_EN) registered XOR reduction of data
//
// Build option: define SIGDATA_PARITY_EN to add the parity output.

module sigdata_gen #(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      LATENCY   = 2,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(4'hC),
  parameter int unsigned      PEND_W    = 2,
  parameter int unsigned      NUM_WORDS = 0
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             ask_for_data,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data,
  output logic             data_vld,
  output logic             busy,
  output logic             done,
  output logic             ovf
`ifdef SIGDATA_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned WordW = (NUM_WORDS > 0) ? $clog2(NUM_WORDS + 1) : 1;
  localparam logic [CntW-1:0]   CntLoad = CntW'(LATENCY - 1);
  localparam logic [PEND_W-1:0] PendMax = '1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              ask_q;
  logic              req_edge;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [WordW-1:0]  words_q, words_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              update;
  logic              budget_met;

  function automatic logic [WIDTH-1:0] next_word(logic [WIDTH-1:0] cur, logic [1:0] m);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (m)
      2'b00: nxt = cur + 1'b1;
      2'b01: nxt = cur - 1'b1;
      2'b10: begin
        // The all-zero state is a lock-up point for the LFSR; kick it out to 1.
        if (cur == '0) begin
          nxt = WIDTH'(1);
        end else begin
          nxt = {1'b0, cur[WIDTH-1:1]} ^ (cur[0] ? TAPS : '0);
        end
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  assign req_edge = ask_for_data & ~ask_q;

  // The word being emitted now is the last one the budget allows.
  assign budget_met = (NUM_WORDS != 0) && (words_q == WordW'(NUM_WORDS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    words_d = words_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    update  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_edge) begin
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          update  = 1'b1;
          data_d  = next_word(data_q, mode);
          words_d = words_q + 1'b1;
          if (budget_met) begin
            state_d = StDone;
            pend_d  = '0;
          end else if (req_edge) begin
            // A fresh edge in the update cycle is consumed directly by the reload.
            cnt_d = CntLoad;
          end else if (pend_q != '0) begin
            cnt_d  = CntLoad;
            pend_d = pend_q - 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (req_edge) begin
            if (pend_q == PendMax) begin
              ovf_d = 1'b1;
            end else begin
              pend_d = pend_q + 1'b1;
            end
          end
        end
      end
      StDone: begin
        // Terminal until reset; requests are ignored.
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= StIdle;
      ask_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= '0;
      words_q <= '0;
      data_q  <= INIT;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ask_q   <= ask_for_data;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      words_q <= words_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data     = data_q;
  assign data_vld = update;
  assign busy     = (state_q == StWait);
  assign done     = (state_q == StDone);
  assign ovf      = ovf_q;

`ifdef SIGDATA_PARITY_EN
  logic parity_q;

  always_ff @(posedge sclk) begin
    if (rst) begin
      parity_q <= ^INIT;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_sigdata_gen.sv
// Bench for sigdata_gen. Four instances with different parameter sets share one clock:
//   u0: defaults                 (increment, LFSR sequence, reset)
//   u1: LATENCY=4                (queuing, reset mid-countdown)
//   u2: LATENCY=8, PEND_W=1      (overflow)
//   u3: NUM_WORDS=3              (word budget, decrement)
// A schedule-based model (outstanding word count + next emission cycle) is compared with
// every instance on every cycle; directed scenarios add literal expectations.

module tb_sigdata_gen;

  logic clk;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       ask  [4];
  logic       rst  [4];
  logic [1:0] mode [4];
  logic [3:0] data [4];
  logic       vld  [4];
  logic       busy [4];
  logic       done [4];
  logic       ovf  [4];
`ifdef SIGDATA_PARITY_EN
  logic       par  [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sigdata_gen #(
      .WIDTH    (4),
      .LATENCY  ((g == 1) ? 4 : (g == 2) ? 8 : 2),
      .INIT     (4'h0),
      .TAPS     (4'hC),
      .PEND_W   ((g == 2) ? 1 : 2),
      .NUM_WORDS((g == 3) ? 3 : 0)
    ) u_dut (
      .sclk        (clk),
      .rst         (rst[g]),
      .ask_for_data(ask[g]),
      .mode        (mode[g]),
      .data        (data[g]),
      .data_vld    (vld[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .ovf         (ovf[g])
`ifdef SIGDATA_PARITY_EN
      ,
      .parity      (par[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- model
  int         m_lat   [4];
  int         m_pmax  [4];
  int         m_nw    [4];
  int         m_n     [4];  // words accepted but not yet emitted
  int         m_head  [4];  // cycle in which the oldest outstanding word is emitted
  int         m_words [4];
  logic [3:0] m_data  [4];
  bit         m_done  [4];
  bit         m_ovf   [4];
  bit         m_prev  [4];
  bit         m_valid [4];

  int vlog[$];
  int log_sel = -1;

  function automatic logic [3:0] model_next(logic [3:0] d, logic [1:0] m);
    int v;
    v = int'(d);
    case (m)
      2'd0: v = (v + 1) % 16;
      2'd1: v = (v + 15) % 16;
      2'd2: v = (v == 0) ? 1 : ((v / 2) ^ (((v % 2) == 1) ? 12 : 0));
      default: v = v;
    endcase
    return 4'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit e;
    bit emit;
    bit last;
    e         = ask[i] && !m_prev[i];
    m_prev[i] = ask[i];
    if (rst[i]) begin
      m_n[i]     = 0;
      m_head[i]  = 0;
      m_words[i] = 0;
      m_data[i]  = 4'h0;
      m_done[i]  = 0;
      m_ovf[i]   = 0;
      m_prev[i]  = 0;
      m_valid[i] = 1;
      return;
    end
    emit = (m_n[i] > 0) && (m_head[i] == cyc);
    last = emit && (m_nw[i] != 0) && (m_words[i] + 1 == m_nw[i]);
    if (e && !m_done[i] && !last) begin
      if (emit || m_n[i] == 0 || (m_n[i] - 1) < m_pmax[i]) begin
        if (m_n[i] == 0) m_head[i] = cyc + m_lat[i];
        m_n[i]++;
      end else begin
        m_ovf[i] = 1;
      end
    end
    if (emit) begin
      m_data[i] = model_next(m_data[i], mode[i]);
      m_words[i]++;
      m_n[i]--;
      m_head[i] += m_lat[i];
      if (last) begin
        m_done[i] = 1;
        m_n[i]    = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i]) begin
        chk($sformatf("u%0d.data", i), 32'(data[i]), 32'(m_data[i]));
        chk($sformatf("u%0d.data_vld", i), 32'(vld[i]),
            32'((m_n[i] > 0) && (m_head[i] == cyc)));
        chk($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(m_n[i] > 0));
        chk($sformatf("u%0d.done", i), 32'(done[i]), 32'(m_done[i]));
        chk($sformatf("u%0d.ovf", i), 32'(ovf[i]), 32'(m_ovf[i]));
`ifdef SIGDATA_PARITY_EN
        chk($sformatf("u%0d.parity", i), 32'(par[i]), 32'(^m_data[i]));
`endif
      end
      if (i == log_sel && vld[i] === 1'b1) vlog.push_back(cyc);
      model_step(i);
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic pulse(input int i, output int c);
    @(posedge clk); #1;
    ask[i] = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    ask[i] = 1'b0;
  endtask

  task automatic wait_vld(input int i, input int budget, output int vc);
    vc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (vld[i] === 1'b1) begin
        vc = cyc;
        break;
      end
    end
    chk($sformatf("u%0d.vld_within_budget", i), 32'(vc >= 0), 32'd1);
  endtask

  task automatic do_rst(input int i);
    @(posedge clk); #1;
    rst[i] = 1'b1;
    @(posedge clk); #1;
    rst[i] = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------------------------------------------------------- directed scenarios
  initial begin
    int c;
    int vc;
    int c0;
    logic [3:0] lfsr_exp [16];
    int         t5_n     [5];
    logic [3:0] t5_d     [5];

    lfsr_exp = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
    t5_n = '{1, 1, 1, 0, 0};
    t5_d = '{4'hF, 4'hE, 4'hD, 4'hD, 4'hD};

    m_lat  = '{2, 4, 8, 2};
    m_pmax = '{3, 3, 1, 3};
    m_nw   = '{0, 0, 0, 3};
    for (int i = 0; i < 4; i++) begin
      ask[i]     = 1'b0;
      rst[i]     = 1'b1;
      mode[i]    = 2'd0;
      m_valid[i] = 0;
      m_n[i]     = 0;
      m_head[i]  = 0;
      m_words[i] = 0;
      m_data[i]  = 4'h0;
      m_done[i]  = 0;
      m_ovf[i]   = 0;
      m_prev[i]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // 1: increment, latency 2, wrap F->0 on the 16th word.
    @(negedge clk);
    chk("t1.reset_data", 32'(data[0]), 32'h0);
    chk("t1.reset_busy", 32'(busy[0]), 32'h0);
    wait_until(4);
    for (int k = 1; k <= 16; k++) begin
      pulse(0, c);
      wait_vld(0, 8, vc);
      chk("t1.latency", 32'(vc - c), 32'd2);
      @(negedge clk);
      chk("t1.data", 32'(data[0]), 32'(k % 16));
    end

    // 2: LFSR from zero, period 15.
    do_rst(0);
    mode[0] = 2'd2;
    @(negedge clk);
    chk("t2.reset_data", 32'(data[0]), 32'h0);
    for (int k = 0; k < 16; k++) begin
      pulse(0, c);
      wait_vld(0, 8, vc);
      @(negedge clk);
      chk("t2.lfsr", 32'(data[0]), 32'(lfsr_exp[k]));
    end

    // 3: three edges two cycles apart with LATENCY=4.
    log_sel = 1;
    vlog.delete();
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      ask[1] = (k % 2 == 0);
      @(posedge clk); #1;
    end
    while (cyc < c0 + 15) begin
      @(negedge clk);
      if (cyc >= c0 + 1 && cyc <= c0 + 12) chk("t3.busy_held", 32'(busy[1]), 32'd1);
      else if (cyc >= c0 + 13) chk("t3.busy_dropped", 32'(busy[1]), 32'd0);
    end
    chk("t3.words", 32'(vlog.size()), 32'd3);
    if (vlog.size() == 3) begin
      chk("t3.first_vld", 32'(vlog[0] - c0), 32'd4);
      chk("t3.gap1", 32'(vlog[1] - vlog[0]), 32'd4);
      chk("t3.gap2", 32'(vlog[2] - vlog[1]), 32'd4);
    end
    chk("t3.ovf", 32'(ovf[1]), 32'd0);
    chk("t3.data", 32'(data[1]), 32'd3);

    // 4: PEND_W=1, LATENCY=8, four edges inside one countdown.
    log_sel = 2;
    vlog.delete();
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      ask[2] = (k % 2 == 0);
      @(posedge clk); #1;
    end
    wait_until(c0 + 30);
    chk("t4.words", 32'(vlog.size()), 32'd2);
    if (vlog.size() == 2) begin
      chk("t4.first_vld", 32'(vlog[0] - c0), 32'd8);
      chk("t4.gap", 32'(vlog[1] - vlog[0]), 32'd8);
    end
    chk("t4.ovf_set", 32'(ovf[2]), 32'd1);
    repeat (5) @(negedge clk);
    chk("t4.ovf_sticky", 32'(ovf[2]), 32'd1);
    do_rst(2);
    @(negedge clk);
    chk("t4.ovf_cleared", 32'(ovf[2]), 32'd0);

    // 5: budget of three words, decrement from zero.
    mode[3] = 2'd1;
    log_sel = 3;
    for (int r = 0; r < 5; r++) begin
      vlog.delete();
      pulse(3, c);
      repeat (6) @(negedge clk);
      chk("t5.vld_count", 32'(vlog.size()), 32'(t5_n[r]));
      chk("t5.data", 32'(data[3]), 32'(t5_d[r]));
      if (r == 1) chk("t5.not_done_yet", 32'(done[3]), 32'd0);
      if (r >= 2) chk("t5.done", 32'(done[3]), 32'd1);
    end
    chk("t5.ovf", 32'(ovf[3]), 32'd0);
    chk("t5.busy", 32'(busy[3]), 32'd0);

    // 6: reset one cycle before an update while a request is queued.
    log_sel = 1;
    vlog.delete();
    @(posedge clk); #1;
    ask[1] = 1'b1;
    @(posedge clk); #1;
    ask[1] = 1'b0;
    @(posedge clk); #1;
    ask[1] = 1'b1;
    @(posedge clk); #1;
    ask[1] = 1'b0;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6.no_vld_after_rst", 32'(vlog.size()), 32'd0);
    chk("t6.data_init", 32'(data[1]), 32'h0);
    chk("t6.busy", 32'(busy[1]), 32'd0);
    pulse(1, c);
    wait_vld(1, 10, vc);
    chk("t6.latency", 32'(vc - c), 32'd4);
    @(negedge clk);
    chk("t6.data_after", 32'(data[1]), 32'h1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigdata_gen.md
Name: sigdata_gen

Overview:
Parametrised, synthesizable successor to the bench stimulus source. It supplies WIDTH-bit words to a downstream consumer on request. Each rising edge of ask_for_data produces exactly one new word after a programmable cycle delay. Features: selectable sequence modes (increment, decrement, LFSR, hold), queuing of requests that arrive while busy, a word budget with done flag, and a sticky overflow flag.

Parameters:
WIDTH, 4, data word width (>=2)
LATENCY, 2, clock cycles from the detected request edge to the data update (>=1)
INIT, 0, reset value of data
TAPS, 4'hC, Galois LFSR feedback mask (WIDTH bits); default is x^4+x^3+1
PEND_W, 2, width of the pending-request counter
NUM_WORDS, 0, words to emit before done; 0 = unlimited

Ports:
sclk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
ask_for_data  input  1  request from consumer; rising edge = one word request
mode  input  2  00 increment, 01 decrement, 10 LFSR, 11 hold
data  output  WIDTH  current word
data_vld  output  1  one-cycle pulse in the cycle data takes a new value
busy  output  1  high while a countdown is active
done  output  1  word budget exhausted
ovf  output  1  sticky: a request was lost to pending-counter saturation

Behaviour:
- Reset (rst=1 at posedge):
  - data=INIT; data_vld=0, busy=0, done=0, ovf=0.
  - Pending count=0, word count=0, edge-detect register=0.
  - State=IDLE. Reset mid-countdown abandons the request; queued requests are discarded.
- Edge detect: req_edge = ask_for_data & ~ask_q, where ask_q is ask_for_data registered on sclk. The input is assumed synchronous to sclk.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on req_edge, load cnt=LATENCY-1 and go to WAIT (busy=1 from the next cycle).
  - WAIT: cnt decrements each cycle. In the cycle with cnt==0:
    - data <= next(data); data_vld=1; word count +1.
    - If the budget is now met (NUM_WORDS!=0 and count==NUM_WORDS), go to DONE.
    - Else if pend>0 or req_edge is present this cycle, reload cnt=LATENCY-1 and stay in WAIT.
    - Else go to IDLE.
  - req_edge in WAIT with cnt!=0: pend+1.
  - Simultaneous req_edge and reload in the same cycle: the reload consumes the edge and pend is unchanged. Otherwise a reload consumes one pend (pend-1).
  - Pend saturates at 2^PEND_W-1. A further edge is dropped and sets ovf=1 until rst.
  - DONE: done=1, busy=0. All req_edges are ignored and do not set ovf. Exit only via rst.
- Net latency: a req_edge in cycle N gives data_vld in cycle N+LATENCY.
- Back-to-back queued words are spaced exactly LATENCY cycles apart.
- next(data), with mode sampled in the update cycle:
  - 00: data+1, wraps at 2^WIDTH-1 to 0.
  - 01: data-1, wraps at 0 to 2^WIDTH-1.
  - 10: if data==0 then 1, else {1'b0, data[WIDTH-1:1]} ^ (data[0] ? TAPS : 0).
  - 11: data unchanged, but data_vld still pulses and the word still counts.
- data only changes in update cycles.

Optional Feature:
- Macro: SIGDATA_PARITY_EN.
- When defined:
  - Extra output port parity (1 bit) = even parity (XOR reduction) of data.
  - parity is registered and updated in the same cycle as data; reset value = ^INIT.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults, mode=00: release rst, pulse ask_for_data high for 1 cycle at cycle 5 -> data_vld at cycle 7, data 0->1. Repeat 16 requests -> data wraps F->0 on the 16th.
2. Mode=10, INIT=0: 16 spaced requests -> data sequence 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1 (period 15).
3. Queuing, LATENCY=4: 3 edges on consecutive even cycles (ask toggling) -> 3 data_vld pulses exactly 4 cycles apart, busy held high throughout, ovf=0.
4. Overflow, PEND_W=1, LATENCY=8: 4 edges inside one countdown -> only 2 words emitted (current + 1 queued), ovf=1 and stays 1 until rst.
5. NUM_WORDS=3, mode=01, INIT=0: 5 requests -> data F,E,D; done=1 after the 3rd data_vld. The 4th and 5th requests produce no data_vld; ovf=0.
6. Reset mid-operation: rst asserted 1 cycle before a pending update with 1 request queued -> data=INIT, no data_vld afterwards, busy=0. A new request then completes normally. With SIGDATA_PARITY_EN, parity matches ^data every cycle.
